// File: rtl/key_pkg.sv
// Shared encodings for the key event controller: event types and per-key FSM states.
package key_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_REPEAT = 2'b11
  } evt_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } key_state_e;

endpackage

// File: rtl/key_press_fsm.sv
// Per-key press classifier: turns one active-low key level into SHORT/LONG/REPEAT strobes.
module key_press_fsm
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC = 8,
  parameter int unsigned REP_CYC  = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_lvl,
  output logic       evt_stb_c,
  output logic [1:0] evt_type_c
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  key_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Event strobes are combinational so the pending slot captures them on the same edge.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    evt_stb_c  = 1'b0;
    evt_type_c = EVT_NONE;
    unique case (state)
      IDLE: begin
        if (!key_lvl) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_lvl) begin
          evt_stb_c  = 1'b1;
          evt_type_c = EVT_SHORT;
          state_nxt  = IDLE;
        end else if (cnt == LONG_LAST) begin
          evt_stb_c  = 1'b1;
          evt_type_c = EVT_LONG;
          state_nxt  = HELD;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_lvl) begin
          state_nxt = IDLE;
        end else if (cnt == REP_LAST) begin
          evt_stb_c  = 1'b1;
          evt_type_c = EVT_REPEAT;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: per-key press classification, pending slots and a round-robin
// arbiter feeding one registered valid/ready event stream.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned LONG_CYC = 1000000,
  parameter int unsigned REP_CYC  = 250000,
  parameter int unsigned CNT_W    = $clog2((LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC) + 1,
  parameter int unsigned IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_lvl,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_key,
  output logic [1:0]          evt_type,
  output logic                evt_ovf
);

  logic [NUM_KEYS-1:0]      stb_c;
  logic [NUM_KEYS-1:0][1:0] stb_type_c;

  logic [NUM_KEYS-1:0]      pend, pend_nxt;
  logic [NUM_KEYS-1:0][1:0] ptype, ptype_nxt;
  logic [IDX_W-1:0]         ptr, ptr_nxt;
  logic [IDX_W-1:0]         gnt_c;
  logic                     gnt_vld_c;
  logic                     load_c;
  logic                     ovf_c;
  logic                     valid_nxt;
  logic [IDX_W-1:0]         key_nxt;
  logic [1:0]               type_nxt;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % NUM_KEYS);
  endfunction

  for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_key
    key_press_fsm #(
      .LONG_CYC (LONG_CYC),
      .REP_CYC  (REP_CYC),
      .CNT_W    (CNT_W)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .key_lvl    (key_lvl[k]),
      .evt_stb_c  (stb_c[k]),
      .evt_type_c (stb_type_c[k])
    );
  end

  // First pending key at or after the round-robin pointer.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_c     = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!gnt_vld_c && pend[wrap_idx(32'(ptr) + i)]) begin
        gnt_vld_c = 1'b1;
        gnt_c     = wrap_idx(32'(ptr) + i);
      end
    end
  end

  // Issue into the output register first; a new event on the issued key re-arms its slot.
  always_comb begin
    load_c    = !evt_valid || evt_ready;
    pend_nxt  = pend;
    ptype_nxt = ptype;
    ptr_nxt   = ptr;
    valid_nxt = evt_valid;
    key_nxt   = evt_key;
    type_nxt  = evt_type;
    ovf_c     = 1'b0;
    if (load_c) begin
      valid_nxt = gnt_vld_c;
      if (gnt_vld_c) begin
        key_nxt         = gnt_c;
        type_nxt        = ptype[gnt_c];
        pend_nxt[gnt_c] = 1'b0;
        ptr_nxt         = wrap_idx(32'(gnt_c) + 32'd1);
      end
    end
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (stb_c[k]) begin
        if (pend[k] && !(load_c && gnt_vld_c && gnt_c == IDX_W'(k))) begin
          ovf_c = 1'b1;
        end
        pend_nxt[k]  = 1'b1;
        ptype_nxt[k] = stb_type_c[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      ptype     <= '0;
      ptr       <= '0;
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= EVT_NONE;
      evt_ovf   <= 1'b0;
    end else begin
      pend      <= pend_nxt;
      ptype     <= ptype_nxt;
      ptr       <= ptr_nxt;
      evt_valid <= valid_nxt;
      evt_key   <= key_nxt;
      evt_type  <= type_nxt;
      evt_ovf   <= ovf_c;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short hold times (LONG_CYC=8, REP_CYC=4).
module tb_key_event_ctrl;

  localparam int unsigned NK = 4;
  localparam int unsigned LC = 8;
  localparam int unsigned RC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_lvl = '1;
  logic          evt_ready = 1'b1;
  logic          evt_valid;
  logic [1:0]    evt_key;
  logic [1:0]    evt_type;
  logic          evt_ovf;

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int ovf_cnt = 0;
  int ovf_cyc = -1;

  typedef struct {
    int key;
    int typ;
    int cyc;
  } ev_t;

  ev_t log_q[$];

  key_event_ctrl #(
    .NUM_KEYS (NK),
    .LONG_CYC (LC),
    .REP_CYC  (RC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_lvl   (key_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .evt_ovf   (evt_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted events and overflow pulses mid-cycle.
  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      ev_t e;
      e.key = int'(evt_key);
      e.typ = int'(evt_type);
      e.cyc = cyc;
      log_q.push_back(e);
    end
    if (evt_ovf) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input int i, input int key, input int typ,
                         input int dcyc, input int p0);
    int k = -1;
    int t = -1;
    int c = -1;
    if (i < log_q.size()) begin
      k = log_q[i].key;
      t = log_q[i].typ;
      c = log_q[i].cyc;
    end
    chk({tag, ".key"}, k, key);
    chk({tag, ".type"}, t, typ);
    chk({tag, ".lat"}, c - p0, dcyc);
  endtask

  task automatic press(input int k, input int n);
    key_lvl[k] = 1'b0;
    step(n);
    key_lvl[k] = 1'b1;
  endtask

  initial begin
    int p0;
    int p1;

    // Reset state
    rst = 1'b1;
    step(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_key", int'(evt_key), 0);
    chk("rst_type", int'(evt_type), 0);
    chk("rst_ovf", int'(evt_ovf), 0);
    rst = 1'b0;
    step(2);

    // Short press of key0
    log_q.delete();
    p0 = cyc;
    press(0, 3);
    step(6);
    chk("short_cnt", log_q.size(), 1);
    chk_evt("short", 0, 0, 1, 5, p0);

    // Long then two repeats on key1
    log_q.delete();
    p0 = cyc;
    press(1, 17);
    step(6);
    chk("lr_cnt", log_q.size(), 3);
    chk_evt("lr_long", 0, 1, 2, 9, p0);
    chk_evt("lr_rep0", 1, 1, 3, 13, p0);
    chk_evt("lr_rep1", 2, 1, 3, 17, p0);

    // Boundary holds on key2
    log_q.delete();
    p0 = cyc;
    press(2, 8);
    step(4);
    chk("b8_cnt", log_q.size(), 1);
    chk_evt("b8", 0, 2, 2, 9, p0);
    log_q.delete();
    p0 = cyc;
    press(2, 7);
    step(4);
    chk("b7_cnt", log_q.size(), 1);
    chk_evt("b7", 0, 2, 1, 9, p0);

    // Round-robin from ptr=0
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    log_q.delete();
    p0 = cyc;
    key_lvl = '0;
    step(2);
    key_lvl = '1;
    step(8);
    chk("rr0_cnt", log_q.size(), 4);
    chk_evt("rr0_a", 0, 0, 1, 4, p0);
    chk_evt("rr0_b", 1, 1, 1, 5, p0);
    chk_evt("rr0_c", 2, 2, 1, 6, p0);
    chk_evt("rr0_d", 3, 3, 1, 7, p0);

    // Move ptr to 2 with a key1 press, then repeat the simultaneous release
    log_q.delete();
    p0 = cyc;
    press(1, 2);
    step(4);
    chk_evt("rr_pre", 0, 1, 1, 4, p0);
    log_q.delete();
    p0 = cyc;
    key_lvl = '0;
    step(2);
    key_lvl = '1;
    step(8);
    chk("rr2_cnt", log_q.size(), 4);
    chk_evt("rr2_a", 0, 2, 1, 4, p0);
    chk_evt("rr2_b", 1, 3, 1, 5, p0);
    chk_evt("rr2_c", 2, 0, 1, 6, p0);
    chk_evt("rr2_d", 3, 1, 1, 7, p0);

    // Backpressure and overflow on key3
    evt_ready = 1'b0;
    log_q.delete();
    ovf_cnt = 0;
    p0 = cyc;
    key_lvl[3] = 1'b0;
    step(10);
    chk("bp_valid0", int'(evt_valid), 1);
    chk("bp_key0", int'(evt_key), 3);
    chk("bp_type0", int'(evt_type), 2);
    step(7);
    key_lvl[3] = 1'b1;
    chk("bp_valid1", int'(evt_valid), 1);
    chk("bp_key1", int'(evt_key), 3);
    chk("bp_type1", int'(evt_type), 2);
    step(3);
    chk("bp_ovf_cnt", ovf_cnt, 1);
    chk("bp_ovf_cyc", ovf_cyc - p0, 16);
    chk("bp_no_accept", log_q.size(), 0);
    evt_ready = 1'b1;
    p1 = cyc;
    step(4);
    chk("bp_cnt", log_q.size(), 2);
    chk_evt("bp_long", 0, 3, 2, 0, p1);
    chk_evt("bp_rep", 1, 3, 3, 1, p1);
    chk("bp_ovf_final", ovf_cnt, 1);

    // Reset in the middle of a key0 press
    log_q.delete();
    p0 = cyc;
    key_lvl[0] = 1'b0;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mr_valid", int'(evt_valid), 0);
    chk("mr_type", int'(evt_type), 0);
    chk("mr_key", int'(evt_key), 0);
    step(10);
    key_lvl[0] = 1'b1;
    step(4);
    chk("mr_cnt", log_q.size(), 1);
    chk_evt("mr_long", 0, 0, 2, 15, p0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
